// File: rtl/seq_shift_unit.sv
// rtl/seq_shift_unit.sv - multi-step shift/rotate engine with start/busy/done handshake
module seq_shift_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [CNT_W-1:0] count,
  input  logic             serial_in,
  input  logic             carry_in,
  input  logic             hold,
  output logic [WIDTH-1:0] out,
  output logic             carry_out,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  localparam logic [2:0] OP_LSL = 3'b000;
  localparam logic [2:0] OP_LSR = 3'b001;
  localparam logic [2:0] OP_ASR = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;
  localparam logic [2:0] OP_RCL = 3'b101;
  localparam logic [2:0] OP_RCR = 3'b110;
  localparam logic [2:0] OP_RSV = 3'b111;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             carry_q, carry_d;
  logic             done_q, done_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] rem_q, rem_d;

  logic [WIDTH-1:0] step_out;
  logic             step_carry;

  // Result of one single-bit step of the latched operation.
  always_comb begin
    step_out   = out_q;
    step_carry = carry_q;
    case (op_q)
      OP_LSL: begin step_out = {out_q[WIDTH-2:0], serial_in};      step_carry = out_q[WIDTH-1]; end
      OP_LSR: begin step_out = {serial_in, out_q[WIDTH-1:1]};      step_carry = out_q[0];       end
      OP_ASR: begin step_out = {out_q[WIDTH-1], out_q[WIDTH-1:1]}; step_carry = out_q[0];       end
      OP_ROL: begin step_out = {out_q[WIDTH-2:0], out_q[WIDTH-1]}; step_carry = out_q[WIDTH-1]; end
      OP_ROR: begin step_out = {out_q[0], out_q[WIDTH-1:1]};       step_carry = out_q[0];       end
      OP_RCL: begin step_out = {out_q[WIDTH-2:0], carry_q};        step_carry = out_q[WIDTH-1]; end
      OP_RCR: begin step_out = {carry_q, out_q[WIDTH-1:1]};        step_carry = out_q[0];       end
      default: begin step_out = out_q;                              step_carry = carry_q;        end
    endcase
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    carry_d = carry_q;
    done_d  = 1'b0;
    op_d    = op_q;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          out_d = din;
        end else if (start) begin
          op_d    = op;
          rem_d   = count;
          carry_d = carry_in;
          // Zero-count and reserved opcode complete immediately without stepping.
          if (count == '0 || op == OP_RSV) begin
            done_d = 1'b1;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        if (!hold) begin
          out_d   = step_out;
          carry_d = step_carry;
          rem_d   = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
      op_q    <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      done_q  <= done_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
    end
  end

  assign out       = out_q;
  assign carry_out = carry_q;
  assign busy      = (state_q == S_SHIFT);
  assign done      = done_q;
  assign zero      = (out_q == '0);

endmodule

// File: tb/tb_seq_shift_unit.sv
// tb/tb_seq_shift_unit.sv - directed self-checking bench for seq_shift_unit
module tb_seq_shift_unit;

  logic       clk;
  logic       rstn;
  logic       load;
  logic [7:0] din;
  logic       start;
  logic [2:0] op;
  logic [3:0] count;
  logic       serial_in;
  logic       carry_in;
  logic       hold;
  logic [7:0] out;
  logic       carry_out;
  logic       busy;
  logic       done;
  logic       zero;

  int n_checks = 0;
  int n_pass   = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  int b0, d0;

  seq_shift_unit #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rstn(rstn), .load(load), .din(din), .start(start), .op(op),
    .count(count), .serial_in(serial_in), .carry_in(carry_in), .hold(hold),
    .out(out), .carry_out(carry_out), .busy(busy), .done(done), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    busy_cnt += int'(busy);
    done_cnt += int'(done);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] d);
    load = 1'b1; din = d;
    tick();
    load = 1'b0;
  endtask

  task automatic do_start(input logic [2:0] o, input logic [3:0] c, input logic ci);
    start = 1'b1; op = o; count = c; carry_in = ci;
    tick();
    start = 1'b0; op = 3'b000; count = 4'd0; carry_in = ~ci;
  endtask

  initial begin
    rstn = 1'b0; load = 1'b0; din = 8'h00; start = 1'b0; op = 3'b000;
    count = 4'd0; serial_in = 1'b0; carry_in = 1'b0; hold = 1'b0;
    tick(); tick();
    chk("rst_out", 32'(out), 32'h00);
    chk("rst_carry", 32'(carry_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);
    rstn = 1'b1;

    // ROL x3 of B4, then back-to-back ROR x1 in the done cycle
    do_load(8'hB4);
    chk("load_out", 32'(out), 32'hB4);
    chk("load_zero", 32'(zero), 32'd0);
    b0 = busy_cnt; d0 = done_cnt;
    do_start(3'b011, 4'd3, 1'b0);
    chk("rol_e0_busy", 32'(busy), 32'd1);
    tick(); chk("rol_e1", 32'(out), 32'h69); chk("rol_e1_c", 32'(carry_out), 32'd1);
    tick(); chk("rol_e2", 32'(out), 32'hD2); chk("rol_e2_c", 32'(carry_out), 32'd0);
    tick(); chk("rol_e3", 32'(out), 32'hA5); chk("rol_e3_c", 32'(carry_out), 32'd1);
    chk("rol_done", 32'(done), 32'd1);
    chk("rol_busy_end", 32'(busy), 32'd0);
    do_start(3'b100, 4'd1, 1'b0);
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_done_low", 32'(done), 32'd0);
    tick(); chk("ror_out", 32'(out), 32'hD2); chk("ror_c", 32'(carry_out), 32'd1);
    chk("ror_done", 32'(done), 32'd1);
    tick();
    chk("rol_ror_busy_cycles", 32'(busy_cnt - b0), 32'd4);
    chk("rol_ror_done_count", 32'(done_cnt - d0), 32'd2);

    // ASR x2 of 90 with carry_in=1
    do_load(8'h90);
    d0 = done_cnt;
    do_start(3'b010, 4'd2, 1'b1);
    chk("asr_e0_c", 32'(carry_out), 32'd1);
    tick(); chk("asr_e1", 32'(out), 32'hC8); chk("asr_e1_c", 32'(carry_out), 32'd0);
    tick(); chk("asr_e2", 32'(out), 32'hE4); chk("asr_e2_c", 32'(carry_out), 32'd0);
    tick(); tick();
    chk("asr_done_count", 32'(done_cnt - d0), 32'd1);

    // RCL x2 of 80 with carry_in=1
    do_load(8'h80);
    do_start(3'b101, 4'd2, 1'b1);
    tick(); chk("rcl_e1", 32'(out), 32'h01); chk("rcl_e1_c", 32'(carry_out), 32'd1);
    tick(); chk("rcl_e2", 32'(out), 32'h03); chk("rcl_e2_c", 32'(carry_out), 32'd0);
    tick();

    // LSR x4 with serial_in=1 and a two-cycle stall after the first step
    do_load(8'h00);
    serial_in = 1'b1;
    b0 = busy_cnt; d0 = done_cnt;
    do_start(3'b001, 4'd4, 1'b1);
    tick(); chk("lsr_e1", 32'(out), 32'h80);
    hold = 1'b1;
    tick(); tick();
    chk("lsr_hold_out", 32'(out), 32'h80);
    chk("lsr_hold_busy", 32'(busy), 32'd1);
    hold = 1'b0;
    tick(); chk("lsr_e4", 32'(out), 32'hC0);
    tick(); tick();
    chk("lsr_final", 32'(out), 32'hF0);
    chk("lsr_final_c", 32'(carry_out), 32'd0);
    chk("lsr_done", 32'(done), 32'd1);
    serial_in = 1'b0;
    tick(); tick();
    chk("lsr_busy_cycles", 32'(busy_cnt - b0), 32'd6);
    chk("lsr_done_count", 32'(done_cnt - d0), 32'd1);

    // LSL x2 of 81, serial_in=0
    do_load(8'h81);
    do_start(3'b000, 4'd2, 1'b0);
    tick(); chk("lsl_e1", 32'(out), 32'h02); chk("lsl_e1_c", 32'(carry_out), 32'd1);
    tick(); chk("lsl_e2", 32'(out), 32'h04); chk("lsl_e2_c", 32'(carry_out), 32'd0);
    tick();

    // load and start together: load wins
    load = 1'b1; din = 8'h5A; start = 1'b1; op = 3'b011; count = 4'd3;
    tick();
    load = 1'b0; start = 1'b0;
    chk("ldst_out", 32'(out), 32'h5A);
    chk("ldst_busy", 32'(busy), 32'd0);
    chk("ldst_done", 32'(done), 32'd0);
    do_start(3'b000, 4'd0, 1'b1);
    chk("cnt0_done", 32'(done), 32'd1);
    chk("cnt0_out", 32'(out), 32'h5A);
    chk("cnt0_c", 32'(carry_out), 32'd1);
    chk("cnt0_busy", 32'(busy), 32'd0);
    tick();
    chk("cnt0_done_off", 32'(done), 32'd0);
    do_start(3'b111, 4'd5, 1'b0);
    chk("rsv_done", 32'(done), 32'd1);
    chk("rsv_out", 32'(out), 32'h5A);
    chk("rsv_c", 32'(carry_out), 32'd0);
    chk("rsv_busy", 32'(busy), 32'd0);
    tick();

    // max count: ROL x15 of 01 equals ROL x7 -> 80
    do_load(8'h01);
    do_start(3'b011, 4'd15, 1'b0);
    begin
      int cyc = 0;
      while (!done && cyc < 40) begin tick(); cyc++; end
      chk("max_cnt_cycles", 32'(cyc), 32'd15);
    end
    chk("max_cnt_out", 32'(out), 32'h80);
    chk("max_cnt_c", 32'(carry_out), 32'd0);
    tick();

    // reset in the middle of a shift aborts without done
    do_load(8'h0F);
    do_start(3'b100, 4'd10, 1'b0);
    tick(); tick(); tick();
    rstn = 1'b0;
    tick();
    chk("mid_rst_out", 32'(out), 32'h00);
    chk("mid_rst_c", 32'(carry_out), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_zero", 32'(zero), 32'd1);
    rstn = 1'b1;
    d0 = done_cnt;
    repeat (15) tick();
    chk("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
